fetch_prefetch_unit: RTL and testbench

//   Parametrised instruction fetch front end. Owns the fetch PC, issues sequential requests to

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_prefetch_unit_if.sv | 42 ++++
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/fetch_prefetch_unit.sv | 108 ++++++++++
 tb/tb_fetch_prefetch_unit.sv | 479 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared fetch-path types and constants (entry layout, widths).
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int DEFAULT_XLEN = 32;
    localparam int DEFAULT_ILEN = 32;
    localparam int ILEN_BYTES   = 4;

    typedef struct packed {
        logic [DEFAULT_XLEN-1:0] pc;
        logic [DEFAULT_ILEN-1:0] inst;
    } fq_entry_t;

    // Counters must be able to hold the full depth, not just depth-1.
    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_prefetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_prefetch_unit_if
// Description : Redirect, instruction-memory and decode handshakes of fetch.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_prefetch_unit_if
    import fetch_pkg::*;
#(
    parameter int XLEN     = DEFAULT_XLEN,
    parameter int ILEN     = DEFAULT_ILEN,
    parameter int FQ_DEPTH = 4
);
    localparam int CW = credit_width(FQ_DEPTH);

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst_pc;
    logic [ILEN-1:0] inst_data;
    logic [CW-1:0]   fq_count;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
               imem_rsp_data, inst_ready,
        output imem_req_valid, imem_req_addr, inst_valid, inst_pc, inst_data, fq_count
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
               imem_rsp_data, inst_ready,
        input  imem_req_valid, imem_req_addr, inst_valid, inst_pc, inst_data, fq_count
    );

endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous prefetch FIFO with flush, registered head, count.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter type T     = fq_entry_t,
    parameter int  DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_flush,
    input  logic                           i_push,
    input  T                               i_push_data,
    input  logic                           i_pop,
    output T                               o_head,
    output logic                           o_valid,
    output logic [credit_width(DEPTH)-1:0] o_count
);
    localparam int CW = credit_width(DEPTH);
    localparam int PW = $clog2(DEPTH);

    T                r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_do_push;
    logic            w_do_pop;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_do_push = i_push && !i_flush;
    assign w_do_pop  = i_pop && (r_count != '0) && !i_flush;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= f_next(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= f_next(r_rd_ptr);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // Storage carries no reset; validity is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (!rst && w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

`ifndef SYNTHESIS
    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        w_do_push |-> (r_count < CW'(DEPTH)));
`endif

endmodule
`default_nettype wire

// File: rtl/fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_prefetch_unit
// Description : Fetch PC, credit-limited imem issue, response drop and queue.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = DEFAULT_XLEN,
    parameter int              ILEN     = DEFAULT_ILEN,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              FQ_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    fetch_prefetch_unit_if.master bus
);
    localparam int              CW        = credit_width(FQ_DEPTH);
    localparam int              SW        = CW + 2;
    localparam logic [XLEN-1:0] c_pc_step = XLEN'(ILEN_BYTES);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } entry_t;

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop_cnt;

    logic [CW-1:0]   w_fq_count;
    logic [SW-1:0]   w_credits_used;
    logic [XLEN-1:0] w_redirect_pc;
    logic [CW-1:0]   w_inflight_after;
    logic            w_req_valid;
    logic            w_req_fire;
    logic            w_rsp_drop;
    logic            w_rsp_keep;
    logic            w_push;
    logic            w_head_valid;
    entry_t          w_push_entry;
    entry_t          w_head;

    assign w_redirect_pc  = bus.redirect_pc & ~XLEN'(3);
    assign w_credits_used = SW'(w_fq_count) + SW'(r_outstanding) + SW'(r_drop_cnt);
    assign w_req_valid    = !reset && !bus.redirect_valid && (w_credits_used < SW'(FQ_DEPTH));
    assign w_req_fire     = w_req_valid && bus.imem_req_ready;
    assign w_rsp_drop     = bus.imem_rsp_valid && (r_drop_cnt != '0);
    assign w_rsp_keep     = bus.imem_rsp_valid && (r_drop_cnt == '0);
    assign w_push         = w_rsp_keep && !bus.redirect_valid;
    // Everything still in flight after this cycle's response becomes garbage on redirect.
    assign w_inflight_after = r_outstanding + r_drop_cnt - CW'(bus.imem_rsp_valid);

    assign w_push_entry.pc   = r_resp_pc;
    assign w_push_entry.inst = bus.imem_rsp_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else if (bus.redirect_valid) begin
            r_fetch_pc    <= w_redirect_pc;
            r_resp_pc     <= w_redirect_pc;
            r_outstanding <= '0;
            r_drop_cnt    <= w_inflight_after;
        end else begin
            if (w_req_fire) r_fetch_pc <= r_fetch_pc + c_pc_step;
            if (w_push)     r_resp_pc  <= r_resp_pc + c_pc_step;
            if (w_rsp_drop) r_drop_cnt <= r_drop_cnt - 1'b1;
            r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_rsp_keep);
        end
    end

    fetch_fifo #(
        .T     (entry_t),
        .DEPTH (FQ_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (reset),
        .i_flush     (bus.redirect_valid),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (bus.inst_ready),
        .o_head      (w_head),
        .o_valid     (w_head_valid),
        .o_count     (w_fq_count)
    );

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_fetch_pc;
    assign bus.inst_valid     = w_head_valid;
    assign bus.inst_pc        = w_head.pc;
    assign bus.inst_data      = w_head.inst;
    assign bus.fq_count       = w_fq_count;

`ifndef SYNTHESIS
    a_credit_bound: assert property (@(posedge clk) disable iff (reset)
        ((SW'(r_outstanding) + SW'(r_drop_cnt)) <= SW'(FQ_DEPTH)));
    a_rsp_expected: assert property (@(posedge clk) disable iff (reset)
        bus.imem_rsp_valid |-> ((r_outstanding != '0) || (r_drop_cnt != '0)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_prefetch_unit
// Description : Scoreboard bench for fetch_prefetch_unit (two PC configurations).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_prefetch_unit;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_prefetch_unit_if #(.XLEN(32), .ILEN(32), .FQ_DEPTH(4)) bus ();
    fetch_prefetch_unit_if #(.XLEN(32), .ILEN(32), .FQ_DEPTH(4)) bus1 ();

    fetch_prefetch_unit #(.XLEN(32), .ILEN(32), .RESET_PC(32'h0), .FQ_DEPTH(4)) dut (
        .clk (clk), .reset (reset), .bus (bus.master)
    );
    fetch_prefetch_unit #(.XLEN(32), .ILEN(32), .RESET_PC(32'hFFFF_FFF8), .FQ_DEPTH(4)) dut_wrap (
        .clk (clk), .reset (reset), .bus (bus1.master)
    );

    int          checks   = 0;
    int          failures = 0;
    logic        mem_stall;
    logic [31:0] mq [$];
    logic [31:0] exp_q [$];
    logic        s_pop, s_fire;
    logic [31:0] s_pc, s_data;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hC0DE_5A5A;
    endfunction

    // In-order memory; mem_stall holds back responses without losing requests.
    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            bus.imem_rsp_valid <= 1'b0;
        end else begin
            if (bus.imem_req_valid && bus.imem_req_ready) mq.push_back(bus.imem_req_addr);
            if (!mem_stall && mq.size() > 0) begin
                bus.imem_rsp_valid <= 1'b1;
                bus.imem_rsp_data  <= inst_of(mq.pop_front());
            end else begin
                bus.imem_rsp_valid <= 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            bus1.imem_rsp_valid <= 1'b0;
        end else begin
            bus1.imem_rsp_valid <= bus1.imem_req_valid && bus1.imem_req_ready;
            bus1.imem_rsp_data  <= inst_of(bus1.imem_req_addr);
        end
    end

    task automatic tick();
        #1;
        s_pop  = bus.inst_valid && bus.inst_ready;
        s_fire = bus.imem_req_valid && bus.imem_req_ready;
        s_pc   = bus.inst_pc;
        s_data = bus.inst_data;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset              = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_req_ready = 1'b1;
        bus.inst_ready     = 1'b0;
        bus1.inst_ready    = 1'b0;
        mem_stall          = 1'b0;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.inst_ready = 1'b0;
        mem_stall = 1'b0;
        tick();
        #1;
        checks++;
        if (bus.imem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0 || bus.fq_count !== 3'd0) begin
            failures++;
            $display("FAIL reset_state req_valid=%b inst_valid=%b fq_count=%0d required 0/0/0",
                     bus.imem_req_valid, bus.inst_valid, bus.fq_count);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin
            failures++;
            $display("FAIL first_request valid=%b addr=%h required 1/00000000",
                     bus.imem_req_valid, bus.imem_req_addr);
        end
    endtask

    task automatic test_stream();
        int first_pop = -1;
        int last_pop  = -1;
        logic [31:0] e;
        do_reset();
        bus.inst_ready = 1'b1;
        for (int k = 0; k < 8; k++) exp_q.push_back(32'(k * 4));
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            tick();
            if (s_pop) begin
                e = exp_q.pop_front();
                checks++;
                if (s_pc !== e || s_data !== inst_of(e)) begin
                    failures++;
                    $display("FAIL stream_pop pc=%h data=%h required pc=%h data=%h", s_pc, s_data, e, inst_of(e));
                end
                if (first_pop < 0) first_pop = c;
                else begin
                    checks++;
                    if (c !== last_pop + 1) begin
                        failures++;
                        $display("FAIL stream_gap pop_cycle=%0d required %0d", c, last_pop + 1);
                    end
                end
                last_pop = c;
            end
        end
        checks++;
        if (exp_q.size() != 0 || first_pop != 2) begin
            failures++;
            $display("FAIL stream_latency first_pop_cycle=%0d left=%0d required 2/0", first_pop, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int fires = 0;
        logic [31:0] e;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            tick();
            if (s_fire) fires++;
        end
        #1;
        checks++;
        if (fires != 4 || bus.imem_req_valid !== 1'b0 || bus.fq_count !== 3'd4) begin
            failures++;
            $display("FAIL bp_full fires=%0d req_valid=%b fq_count=%0d required 4/0/4",
                     fires, bus.imem_req_valid, bus.fq_count);
        end
        bus.inst_ready = 1'b1;
        tick();
        checks++;
        if (s_pop !== 1'b1 || s_pc !== 32'h0) begin
            failures++;
            $display("FAIL bp_single_pop pop=%b pc=%h required 1/00000000", s_pop, s_pc);
        end
        bus.inst_ready = 1'b0;
        #1;
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.fq_count !== 3'd3) begin
            failures++;
            $display("FAIL bp_resume req_valid=%b fq_count=%0d required 1/3", bus.imem_req_valid, bus.fq_count);
        end
        tick();
        #1;
        checks++;
        if (bus.imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_one_per_pop req_valid=%b required 0", bus.imem_req_valid);
        end
        bus.inst_ready = 1'b1;
        for (int k = 1; k < 8; k++) exp_q.push_back(32'(k * 4));
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            tick();
            if (s_pop) begin
                e = exp_q.pop_front();
                checks++;
                if (s_pc !== e || s_data !== inst_of(e)) begin
                    failures++;
                    $display("FAIL bp_drain pc=%h data=%h required pc=%h data=%h", s_pc, s_data, e, inst_of(e));
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL bp_timeout left=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_req_stall();
        logic [31:0] e;
        do_reset();
        bus.imem_req_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin
                failures++;
                $display("FAIL stall_hold cycle=%0d valid=%b addr=%h required 1/00000000",
                         c, bus.imem_req_valid, bus.imem_req_addr);
            end
            tick();
        end
        bus.imem_req_ready = 1'b1;
        tick();
        #1;
        checks++;
        if (bus.imem_req_addr !== 32'h4) begin
            failures++;
            $display("FAIL stall_advance addr=%h required 00000004", bus.imem_req_addr);
        end
        bus.inst_ready = 1'b1;
        for (int k = 0; k < 3; k++) exp_q.push_back(32'(k * 4));
        for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
            tick();
            if (s_pop) begin
                e = exp_q.pop_front();
                checks++;
                if (s_pc !== e || s_data !== inst_of(e)) begin
                    failures++;
                    $display("FAIL stall_drain pc=%h data=%h required pc=%h", s_pc, s_data, e);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL stall_timeout left=%0d required 0", exp_q.size());
        end
    endtask

    // Fires n requests while memory is stalled, so they remain outstanding.
    task automatic issue_stalled(input int n);
        mem_stall = 1'b1;
        bus.imem_req_ready = 1'b1;
        for (int c = 0; c < n; c++) tick();
        bus.imem_req_ready = 1'b0;
    endtask

    task automatic test_redirect();
        logic [31:0] e;
        // One queued entry plus two outstanding, then redirect.
        do_reset();
        tick();
        mem_stall = 1'b1;
        tick();
        tick();
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        #1;
        checks++;
        if (bus.imem_req_valid !== 1'b0 || bus.fq_count !== 3'd1) begin
            failures++;
            $display("FAIL redir_cycle req_valid=%b fq_count=%0d required 0/1", bus.imem_req_valid, bus.fq_count);
        end
        tick();
        bus.redirect_valid = 1'b0;
        mem_stall = 1'b0;
        bus.imem_req_ready = 1'b1;
        #1;
        checks++;
        if (bus.fq_count !== 3'd0 || bus.inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL redir_flush fq_count=%0d inst_valid=%b required 0/0", bus.fq_count, bus.inst_valid);
        end
        bus.inst_ready = 1'b1;
        for (int k = 0; k < 4; k++) exp_q.push_back(32'h100 + 32'(k * 4));
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            tick();
            if (s_pop) begin
                e = exp_q.pop_front();
                checks++;
                if (s_pc !== e || s_data !== inst_of(e)) begin
                    failures++;
                    $display("FAIL redir_pop pc=%h data=%h required pc=%h data=%h", s_pc, s_data, e, inst_of(e));
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL redir_timeout left=%0d required 0", exp_q.size());
        end

        // Three outstanding; the oldest response lands in the redirect cycle.
        do_reset();
        issue_stalled(3);
        mem_stall = 1'b0;
        tick();
        mem_stall = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h203;
        tick();
        bus.redirect_valid = 1'b0;
        mem_stall = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.inst_ready = 1'b1;
        for (int k = 0; k < 3; k++) exp_q.push_back(32'h200 + 32'(k * 4));
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            tick();
            if (s_pop) begin
                e = exp_q.pop_front();
                checks++;
                if (s_pc !== e || s_data !== inst_of(e)) begin
                    failures++;
                    $display("FAIL redir_rsp_pop pc=%h data=%h required pc=%h data=%h", s_pc, s_data, e, inst_of(e));
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL redir_rsp_timeout left=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        do_reset();
        issue_stalled(2);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h500;
        tick();
        bus.redirect_pc    = 32'h600;
        tick();
        bus.redirect_valid = 1'b0;
        mem_stall = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.inst_ready = 1'b1;
        for (int k = 0; k < 3; k++) exp_q.push_back(32'h600 + 32'(k * 4));
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            tick();
            if (s_pop) begin
                e = exp_q.pop_front();
                checks++;
                if (s_pc !== e || s_data !== inst_of(e)) begin
                    failures++;
                    $display("FAIL b2b_pop pc=%h data=%h required pc=%h data=%h", s_pc, s_data, e, inst_of(e));
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_timeout left=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_pc_wrap();
        logic [31:0] e;
        do_reset();
        bus1.inst_ready = 1'b1;
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
            #1;
            if (bus1.inst_valid && bus1.inst_ready) begin
                e = exp_q.pop_front();
                checks++;
                if (bus1.inst_pc !== e || bus1.inst_data !== inst_of(e)) begin
                    failures++;
                    $display("FAIL wrap_pop pc=%h data=%h required pc=%h data=%h",
                             bus1.inst_pc, bus1.inst_data, e, inst_of(e));
                end
            end
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL wrap_timeout left=%0d required 0", exp_q.size());
        end
        bus1.inst_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic [31:0] e;
        do_reset();
        tick();
        tick();
        tick();
        mem_stall = 1'b1;
        tick();
        #1;
        checks++;
        if (bus.fq_count !== 3'd3) begin
            failures++;
            $display("FAIL midrst_setup fq_count=%0d required 3", bus.fq_count);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mem_stall = 1'b0;
        #1;
        checks++;
        if (bus.inst_valid !== 1'b0 || bus.fq_count !== 3'd0 ||
            bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin
            failures++;
            $display("FAIL midrst_clear inst_valid=%b fq_count=%0d req_valid=%b addr=%h required 0/0/1/00000000",
                     bus.inst_valid, bus.fq_count, bus.imem_req_valid, bus.imem_req_addr);
        end
        bus.inst_ready = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
            tick();
            if (s_pop) begin
                e = exp_q.pop_front();
                checks++;
                if (s_pc !== e || s_data !== inst_of(e)) begin
                    failures++;
                    $display("FAIL midrst_pop pc=%h data=%h required pc=%h", s_pc, s_data, e);
                end
            end
        end
        bus.inst_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h103;
        tick();
        bus.redirect_valid = 1'b0;
        bus.inst_ready = 1'b1;
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
            tick();
            if (s_pop) begin
                e = exp_q.pop_front();
                checks++;
                if (s_pc !== e || s_data !== inst_of(e)) begin
                    failures++;
                    $display("FAIL midrst_redir_pop pc=%h data=%h required pc=%h", s_pc, s_data, e);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL midrst_timeout left=%0d required 0", exp_q.size());
        end
    endtask

    initial begin
        bus1.redirect_valid = 1'b0;
        bus1.redirect_pc    = '0;
        bus1.imem_req_ready = 1'b1;
        bus1.inst_ready     = 1'b0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_req_stall();
        test_redirect();
        test_back_to_back();
        test_pc_wrap();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
